// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture path: default frame geometry,
// counter widths and the capture FSM state encoding.
package camera_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COL_W        = 10;
    localparam int ROW_W        = 9;
    localparam int RGB565_W     = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } cap_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser with a trailing delay flop; provides the synced level and
// single-cycle rise/fall pulses in the destination clock domain.
module cam_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level_s,
    output logic rise_s,
    output logic fall_s
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Synchroniser chain plus the delay stage used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign level_s = sync2_q;
    assign rise_s  = sync2_q & ~dly_q;
    assign fall_s  = ~sync2_q & dly_q;

endmodule

// File: rtl/camera_pixel_capture.sv
// Camera pin capture: synchronises PCLK/VSYNC/HREF/D into CLK and assembles byte
// pairs into RGB565 pixels with column/row coordinates and frame strobes.
module camera_pixel_capture
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                START,
    input  logic                PCLK,
    input  logic                VSYNC,
    input  logic                HREF,
    input  logic [7:0]          D,
    output logic [RGB565_W-1:0] PIXEL_RGB565,
    output logic                PIXEL_VALID,
    output logic [COL_W-1:0]    PIXEL_COLUMN,
    output logic [ROW_W-1:0]    PIXEL_ROW,
    output logic                FRAME_START,
    output logic                FRAME_DONE,
    output logic                ERROR
);

    localparam logic [COL_W-1:0] H_MAX = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_MAX = ROW_W'(V_ACTIVE);

    logic pclk_lvl_s, pclk_rise_s, pclk_fall_s;
    logic vsync_lvl_s, vsync_rise_s, vsync_fall_s;
    logic href_lvl_s, href_rise_s, href_fall_s;
    logic unused_edges_s;

    cam_sync_edge u_sync_pclk (
        .clk(CLK), .rst_n(RESET_N), .async_in(PCLK),
        .level_s(pclk_lvl_s), .rise_s(pclk_rise_s), .fall_s(pclk_fall_s)
    );
    cam_sync_edge u_sync_vsync (
        .clk(CLK), .rst_n(RESET_N), .async_in(VSYNC),
        .level_s(vsync_lvl_s), .rise_s(vsync_rise_s), .fall_s(vsync_fall_s)
    );
    cam_sync_edge u_sync_href (
        .clk(CLK), .rst_n(RESET_N), .async_in(HREF),
        .level_s(href_lvl_s), .rise_s(href_rise_s), .fall_s(href_fall_s)
    );

    assign unused_edges_s = ^{pclk_lvl_s, pclk_fall_s, vsync_lvl_s, href_rise_s};

    logic [7:0]          d_s1_q, d_s2_q;
    cap_state_e          state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                phase_q, phase_d;
    logic [7:0]          hi_q, hi_d;
    logic [RGB565_W-1:0] pix_q, pix_d;
    logic [COL_W-1:0]    pcol_q, pcol_d;
    logic [ROW_W-1:0]    prow_q, prow_d;
    logic                valid_q, valid_d;
    logic                fstart_q, fstart_d;
    logic                fdone_q, fdone_d;
    logic                err_q, err_d;

    // Data byte pipeline, kept the same depth as the PCLK synchroniser
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            d_s1_q <= 8'h00;
            d_s2_q <= 8'h00;
        end else begin
            d_s1_q <= D;
            d_s2_q <= d_s1_q;
        end
    end

    // Capture FSM: next state, counters and registered output values
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        phase_d  = phase_q;
        hi_d     = hi_q;
        pix_d    = pix_q;
        pcol_d   = pcol_q;
        prow_d   = prow_q;
        valid_d  = 1'b0;
        fstart_d = 1'b0;
        fdone_d  = 1'b0;
        err_d    = err_q;

        if (!START) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    // Only a VSYNC falling edge arms a frame, so a mid-frame START waits
                    if (vsync_fall_s) begin
                        state_d  = ACTIVE;
                        fstart_d = 1'b1;
                        col_d    = '0;
                        row_d    = '0;
                        phase_d  = 1'b0;
                        err_d    = 1'b0;
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end
                ACTIVE: begin
                    if (vsync_rise_s) begin
                        state_d = WAIT_FRAME;
                        fdone_d = 1'b1;
                        if (row_q != V_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end else if (href_fall_s) begin
                        // A byte arriving with the line end is dropped
                        if (phase_q || (col_q != H_MAX)) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                        if ((col_q != '0) && (row_q < V_MAX)) begin
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            row_d = row_q;
                        end
                        col_d   = '0;
                        phase_d = 1'b0;
                    end else if (pclk_rise_s && href_lvl_s) begin
                        if (!phase_q) begin
                            hi_d    = d_s2_q;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if ((col_q >= H_MAX) || (row_q >= V_MAX)) begin
                                err_d = 1'b1;
                            end else begin
                                pix_d   = {hi_q, d_s2_q};
                                pcol_d  = col_q;
                                prow_d  = row_q;
                                valid_d = 1'b1;
                                col_d   = col_q + COL_W'(1);
                            end
                        end
                    end else begin
                        state_d = ACTIVE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            phase_q  <= 1'b0;
            hi_q     <= 8'h00;
            pix_q    <= '0;
            pcol_q   <= '0;
            prow_q   <= '0;
            valid_q  <= 1'b0;
            fstart_q <= 1'b0;
            fdone_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            phase_q  <= phase_d;
            hi_q     <= hi_d;
            pix_q    <= pix_d;
            pcol_q   <= pcol_d;
            prow_q   <= prow_d;
            valid_q  <= valid_d;
            fstart_q <= fstart_d;
            fdone_q  <= fdone_d;
            err_q    <= err_d;
        end
    end

    assign PIXEL_RGB565 = pix_q;
    assign PIXEL_VALID  = valid_q;
    assign PIXEL_COLUMN = pcol_q;
    assign PIXEL_ROW    = prow_q;
    assign FRAME_START  = fstart_q;
    assign FRAME_DONE   = fdone_q;
    assign ERROR        = err_q;

endmodule

// File: doc/camera_pixel_capture.md
# camera_pixel_capture

Capture front end for the OV7670-style camera path. It synchronises the raw camera pins (PCLK, VSYNC, HREF, D) into the system clock domain and assembles byte pairs into RGB565 pixels. Each pixel is emitted with its column/row coordinates and frame-boundary strobes. It feeds the colour-filter and frame-buffer stages downstream and replaces ad-hoc per-stage pin sampling.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line expected per HREF
- V_ACTIVE, 480, lines per frame expected between VSYNC pulses

Ports:
- CLK  in  1  system clock; must be ≥ 4× PCLK frequency
- RESET_N  in  1  reset, asynchronous, active-low
- START  in  1  enable capture; level-sensitive
- PCLK  in  1  camera pixel clock, asynchronous to CLK
- VSYNC  in  1  camera frame sync; high between frames
- HREF  in  1  camera line valid; high during active bytes
- D  in  8  camera data byte
- PIXEL_RGB565  out  16  assembled pixel {first byte, second byte}
- PIXEL_VALID  out  1  one-CLK strobe; pixel and coordinates valid
- PIXEL_COLUMN  out  10  column of current pixel, 0..H_ACTIVE-1
- PIXEL_ROW  out  9  row of current pixel, 0..V_ACTIVE-1
- FRAME_START  out  1  one-CLK strobe at VSYNC falling edge while armed
- FRAME_DONE  out  1  one-CLK strobe at VSYNC rising edge ending a captured frame
- ERROR  out  1  sticky framing error for the current/last frame

## Operation
- PCLK, VSYNC, HREF and D each pass through two CLK flops (D kept in lockstep with PCLK). A third flop on the control lines gives edge detect.
- Events used: pclk_rise, vsync_fall, vsync_rise, href_fall.
- FSM states:
  - IDLE: entered from reset or on START low.
  - IDLE → WAIT_FRAME when START=1.
  - WAIT_FRAME → ACTIVE on vsync_fall. Pulse FRAME_START, clear row/col/phase/ERROR. Capture never starts mid-frame.
  - ACTIVE, on pclk_rise with synced HREF=1:
    - phase 0: latch D as high byte.
    - phase 1: PIXEL_RGB565 ← {hi, D}, PIXEL_VALID=1, present current column/row, then column+1.
  - ACTIVE, on href_fall:
    - odd byte count (phase=1) → ERROR.
    - column≠H_ACTIVE → ERROR.
    - if column≠0, row+1; then column←0 and phase←0.
  - ACTIVE → WAIT_FRAME on vsync_rise. Pulse FRAME_DONE; if row≠V_ACTIVE, set ERROR.
  - Any state → IDLE when START=0. No FRAME_DONE is issued; a partial frame is abandoned.
- Overflow: a pixel with column ≥ H_ACTIVE or row ≥ V_ACTIVE is not emitted (no PIXEL_VALID) and sets ERROR. Counters saturate at H_ACTIVE and V_ACTIVE and do not wrap.
- Simultaneous events in one CLK:
  - href_fall with pclk_rise: href_fall wins and the byte is dropped.
  - vsync_rise with anything: vsync_rise wins.
  - START low: overrides all.

## Timing
- Reset values:
  - outputs: PIXEL_RGB565=0, PIXEL_VALID=0, PIXEL_COLUMN=0, PIXEL_ROW=0, FRAME_START=0, FRAME_DONE=0, ERROR=0
  - FSM=IDLE; synchroniser flops=0
- Latency: let edge n be the first CLK edge sampling PCLK=1 on the second byte. PIXEL_VALID is high after edge n+2, for exactly one cycle.
- FRAME_START and FRAME_DONE follow the same 2-cycle latency from pin transition to strobe.
- PIXEL_RGB565, PIXEL_COLUMN and PIXEL_ROW hold their values between strobes.
- ERROR changes only at FRAME_START (clear) or on a detected fault (set).

## Structure
- Shared package camera_pkg holds:
  - H_ACTIVE_DEF, V_ACTIVE_DEF
  - FSM state constants (IDLE, WAIT_FRAME, ACTIVE)
  - COL_W=10, ROW_W=9
  - RGB565 width constant
- One sub-module, cam_sync_edge: 2-flop synchroniser plus delay flop, outputs synced level, rise and fall. Instantiated for PCLK, VSYNC and HREF.
- D uses a plain 2-stage register in the top level.

## Test plan
- Reset mid-line (RESET_N low for 1 CLK during HREF) → all outputs 0 and FSM IDLE immediately. With START=1, no pixel until the next vsync_fall.
- START=1, one 4×3 frame (H_ACTIVE=4, V_ACTIVE=3 override), byte pairs 0xF8,0x1F… → 12 PIXEL_VALID strobes, first 0xF81F at col 0/row 0, last at col 3/row 2. FRAME_START and FRAME_DONE each once, ERROR=0.
- START asserted while VSYNC low (mid-frame) → no pixels until the following vsync_fall, then a full frame.
- Line with 7 bytes (odd) → 3 pixels emitted, ERROR=1 at href_fall, next line starts at column 0.
- Line with 6 pixels when H_ACTIVE=4 → pixels at columns 0..3 only, ERROR=1. Frame with 4 lines when V_ACTIVE=3 → ERROR=1.
- START dropped during row 1 → FSM IDLE within one CLK, no FRAME_DONE, no further PIXEL_VALID.
